// File: rtl/day4_alu_if.sv
// Operand/result bundle for day4_alu; master drives operands, slave returns results.
// zero_o exists only when ALU_ZERO_FLAG_EN is defined.
interface day4_alu_if;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [2:0] op_i;
  logic [7:0] alu_o;
  logic       carry_o;
`ifdef ALU_ZERO_FLAG_EN
  logic       zero_o;

  modport master (output a_i, output b_i, output op_i,
                  input alu_o, input carry_o, input zero_o);
  modport slave  (input a_i, input b_i, input op_i,
                  output alu_o, output carry_o, output zero_o);
`else
  modport master (output a_i, output b_i, output op_i,
                  input alu_o, input carry_o);
  modport slave  (input a_i, input b_i, input op_i,
                  output alu_o, output carry_o);
`endif
endinterface

// File: rtl/day4_alu.sv
// Registered 8-bit ALU with one-cycle latency and async active-low reset.
// Optional registered zero flag enabled by defining ALU_ZERO_FLAG_EN.
module day4_alu (
  input  logic       clk,
  input  logic       reset_n,
  day4_alu_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_LSR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQL = 3'b111
  } alu_op_e;

  logic [8:0] sum_s;
  logic [7:0] diff_s;
  logic [7:0] alu_d;
  logic [7:0] alu_q;
  logic       carry_d;
  logic       carry_q;

  assign sum_s  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign diff_s = bus.a_i - bus.b_i;

  // Next-state result selection; shifts only look at b_i[2:0]
  always_comb begin
    alu_d   = 8'h00;
    carry_d = 1'b0;
    case (bus.op_i)
      OP_ADD: begin
        alu_d   = sum_s[7:0];
        carry_d = sum_s[8];
      end
      OP_SUB: begin
        alu_d   = diff_s;
        carry_d = (bus.a_i < bus.b_i);
      end
      OP_SLL: alu_d = bus.a_i << bus.b_i[2:0];
      OP_LSR: alu_d = bus.a_i >> bus.b_i[2:0];
      OP_AND: alu_d = bus.a_i & bus.b_i;
      OP_OR:  alu_d = bus.a_i | bus.b_i;
      OP_XOR: alu_d = bus.a_i ^ bus.b_i;
      OP_EQL: alu_d = {7'b000_0000, (bus.a_i == bus.b_i)};
      default: begin
        alu_d   = 8'h00;
        carry_d = 1'b0;
      end
    endcase
  end

  // Result and carry registers; reset discards any in-flight result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_q   <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      carry_q <= carry_d;
    end
  end

  assign bus.alu_o   = alu_q;
  assign bus.carry_o = carry_q;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag tracks the value being loaded into alu_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= (alu_d == 8'h00);
    end
  end

  assign bus.zero_o = zero_q;
`endif

endmodule

// File: tb/tb_day4_alu.sv
// Scoreboard bench for day4_alu: driver pushes hand-computed expectations,
// a monitor pops and compares one cycle later.
module tb_day4_alu;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  day4_alu_if bus ();

  day4_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] alu;
    logic       carry;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id,
                       input logic [7:0] act, input logic [7:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s #%0d: got %h expected %h", name, id, act, expv);
    end
  endtask

  task automatic check_reset_outputs(input int id);
    check("rst_alu", id, bus.alu_o, 8'h00);
    check("rst_carry", id, {7'b000_0000, bus.carry_o}, 8'h00);
`ifdef ALU_ZERO_FLAG_EN
    check("rst_zero", id, {7'b000_0000, bus.zero_o}, 8'h01);
`endif
  endtask

  task automatic push(input logic [7:0] ea, input logic ec, input int id);
    exp_t e;
    e.alu   = ea;
    e.carry = ec;
    e.id    = id;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] ea,
                       input logic ec, input int id);
    @(negedge clk);
    bus.op_i = op;
    bus.a_i  = a;
    bus.b_i  = b;
    push(ea, ec, id);
  endtask

  // Monitor: every cycle the DUT presents a new result one tick after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("alu", mon_e.id, bus.alu_o, mon_e.alu);
      check("carry", mon_e.id, {7'b000_0000, bus.carry_o}, {7'b000_0000, mon_e.carry});
`ifdef ALU_ZERO_FLAG_EN
      check("zero", mon_e.id, {7'b000_0000, bus.zero_o},
            {7'b000_0000, (mon_e.alu == 8'h00)});
`endif
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b1;
    bus.a_i  = 8'hFF;
    bus.b_i  = 8'hFF;
    bus.op_i = 3'b000;

    // Reset applied between edges must act immediately and hold over clocks
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(0);
    @(posedge clk); #1;
    check_reset_outputs(1);
    @(posedge clk); #1;
    check_reset_outputs(2);

    // Release: held FF+FF ADD is the first capture
    @(negedge clk);
    reset_n = 1'b1;
    push(8'hFE, 1'b1, 10);

    drive(3'b000, 8'd255, 8'd255, 8'd254, 1'b1, 11);
    drive(3'b000, 8'd10,  8'd20,  8'd30,  1'b0, 12);
    drive(3'b001, 8'd253, 8'd255, 8'd254, 1'b1, 13);
    drive(3'b001, 8'd100, 8'd40,  8'd60,  1'b0, 14);
    drive(3'b010, 8'h81,  8'd9,   8'h02,  1'b0, 15);
    drive(3'b011, 8'h81,  8'd9,   8'h40,  1'b0, 16);
    drive(3'b100, 8'hF0,  8'h3C,  8'h30,  1'b0, 17);
    drive(3'b101, 8'hF0,  8'h3C,  8'hFC,  1'b0, 18);
    drive(3'b110, 8'hF0,  8'h3C,  8'hCC,  1'b0, 19);
    drive(3'b111, 8'h5A,  8'h5A,  8'h01,  1'b0, 20);
    drive(3'b111, 8'h5A,  8'h5B,  8'h00,  1'b0, 21);
    drive(3'b001, 8'h42,  8'h42,  8'h00,  1'b0, 22);

    // Back-to-back stream, opcode changes every cycle
    drive(3'b000, 8'h7F,  8'h01,  8'h80,  1'b0, 30);
    drive(3'b001, 8'h00,  8'h01,  8'hFF,  1'b1, 31);
    drive(3'b010, 8'hFF,  8'h07,  8'h80,  1'b0, 32);
    drive(3'b011, 8'hFF,  8'h07,  8'h01,  1'b0, 33);
    drive(3'b100, 8'hAA,  8'h55,  8'h00,  1'b0, 34);
    drive(3'b101, 8'hAA,  8'h55,  8'hFF,  1'b0, 35);
    drive(3'b110, 8'hFF,  8'h0F,  8'hF0,  1'b0, 36);
    drive(3'b111, 8'h00,  8'h00,  8'h01,  1'b0, 37);
    drive(3'b010, 8'h81,  8'h08,  8'h81,  1'b0, 38);
    drive(3'b011, 8'h81,  8'h00,  8'h81,  1'b0, 39);

    // Mid-stream reset pulse: pending ADD must be discarded, not delayed
    @(negedge clk);
    bus.op_i = 3'b000;
    bus.a_i  = 8'hFF;
    bus.b_i  = 8'hFF;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(40);
    @(posedge clk); #1;
    check_reset_outputs(41);

    @(negedge clk);
    reset_n = 1'b1;
    push(8'hFE, 1'b1, 42);
    drive(3'b001, 8'd5, 8'd3, 8'd2, 1'b0, 43);

    @(posedge clk); #3;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
